aoi5: RTL and testbench
=======================

AOI5 -- requirements
Module: aoi5

Interface
REQ-001 Parameter CNT_W, default 16, sets the width of the output-toggle counter; legal range 4..32.
REQ-002 Port clk  input  1  clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  reset; synchronous, active-high.
REQ-004 Ports A, B  input  1 each  product term 0 operands.
REQ-005 Ports C, D  input  1 each  product term 1 operands.
REQ-006 Ports E, F  input  1 each  product term 2 operands.
REQ-007 Ports G, H  input  1 each  product term 3 operands.
REQ-008 Port Y  output  1  combinational AOI result.
REQ-009 Port y_q  output  1  registered copy of Y.
REQ-010 Port term_q  output  4  registered product terms; bit i is term i.
REQ-011 Port active_cnt  output  3  registered count of true product terms, range 0..4.
REQ-012 Port toggle_cnt  output  CNT_W  count of y_q transitions.

Function
REQ-013 Y SHALL equal NOT((A AND B) OR (C AND D) OR (E AND F) OR (G AND H)), with zero latency and no dependence on clk or rst.
REQ-014 term_q SHALL load {G&H, E&F, C&D, A&B} each cycle, with bit 0 = A&B; latency is 1 cycle.
REQ-015 y_q SHALL load Y each cycle; latency is 1 cycle.
REQ-016 active_cnt SHALL load the population count of the four product terms each cycle; latency is 1 cycle.
REQ-017 toggle_cnt SHALL increment by 1 on each cycle where the next y_q value differs from the current y_q.
REQ-018 toggle_cnt SHALL saturate at all-ones and SHALL NOT wrap around.
REQ-019 Inputs SHALL be sampled only at the rising edge of clk; there is no handshake and no state machine.

Reset
REQ-020 While rst=1 at a clk edge: y_q=1, term_q=4'b0000, active_cnt=0, toggle_cnt=0.
REQ-021 Reset SHALL take priority over all updates, including a coincident Y change.
REQ-022 The first edge after rst deasserts SHALL load normally; a y_q change from its reset value of 1 on that edge SHALL count as a toggle.
REQ-023 Y SHALL remain purely combinational during reset.

Configuration
REQ-024 Macro AOI5_TOGGLE_CNT_EN:
- Defined: the toggle counter is implemented as specified in REQ-017 and REQ-018.
- Undefined: the counter logic is removed, the toggle_cnt port remains, and toggle_cnt is tied to 0.

Structure
REQ-025 Package aoi5_pkg SHALL hold:
- NUM_TERMS = 4
- the default CNT_W
- the typedef term_vec_t (4-bit)
REQ-026 Sub-module aoi5_term SHALL compute one 2-input AND term; aoi5 SHALL instantiate it four times.

Verification
REQ-027 All inputs 0, no reset -> Y=1; after 1 edge: y_q=1, term_q=0000, active_cnt=0.
REQ-028 A=C=E=G=1 with B=D=F=H=0 -> Y=1, term_q=0000, active_cnt=0.
REQ-029 A=B=1, others 0 -> Y=0 immediately; next edge: term_q=0001, active_cnt=1, y_q=0, toggle_cnt +1.
REQ-030 All inputs 1 -> Y=0; next edge: term_q=1111, active_cnt=4.
REQ-031 Toggle A&B every cycle for 2^CNT_W+5 cycles with CNT_W=4 and the macro defined -> toggle_cnt holds at 15; assert rst mid-run -> all registers reach reset values on that edge.
REQ-032 Macro undefined, same stimulus -> toggle_cnt=0 throughout; Y, y_q and term_q unchanged from the defined build.

Source files
------------

// File: rtl/aoi5_pkg.sv
// Shared constants, types and helpers for the aoi5 AND-OR-INVERT block.
// Optional toggle counter is enabled by defining AOI5_TOGGLE_CNT_EN.
package aoi5_pkg;

    localparam int NUM_TERMS     = 4;
    localparam int CNT_W_DEFAULT = 16;

    typedef logic [NUM_TERMS-1:0] term_vec_t;

    // Number of product terms that are currently true (0..NUM_TERMS).
    function automatic logic [2:0] term_popcount(input term_vec_t terms);
        logic [2:0] sum;
        sum = '0;
        for (int i = 0; i < NUM_TERMS; i++) begin
            sum = sum + {2'b00, terms[i]};
        end
        return sum;
    endfunction

endpackage

// File: rtl/aoi5_term.sv
// One 2-input AND product term of the aoi5 block.
module aoi5_term (
    input  logic a,
    input  logic b,
    output logic p
);

    assign p = a & b;

endmodule

// File: rtl/aoi5.sv
// Four-term AND-OR-INVERT gate with registered copies, term population count
// and an optional saturating output-toggle counter (macro AOI5_TOGGLE_CNT_EN).
module aoi5
    import aoi5_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             A,
    input  logic             B,
    input  logic             C,
    input  logic             D,
    input  logic             E,
    input  logic             F,
    input  logic             G,
    input  logic             H,
    output logic             Y,
    output logic             y_q,
    output logic [3:0]       term_q,
    output logic [2:0]       active_cnt,
    output logic [CNT_W-1:0] toggle_cnt
);

    logic [NUM_TERMS-1:0] op_a;
    logic [NUM_TERMS-1:0] op_b;
    term_vec_t            term_next;

    assign op_a = {G, E, C, A};
    assign op_b = {H, F, D, B};

    generate
        for (genvar gi = 0; gi < NUM_TERMS; gi++) begin : g_term
            aoi5_term u_term (
                .a (op_a[gi]),
                .b (op_b[gi]),
                .p (term_next[gi])
            );
        end
    endgenerate

    // Combinational result; independent of clk and rst.
    assign Y = ~(|term_next);

    logic       y_q_reg;
    term_vec_t  term_q_reg;
    logic [2:0] active_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q_reg        <= 1'b1;
            term_q_reg     <= '0;
            active_cnt_reg <= '0;
        end else begin
            y_q_reg        <= Y;
            term_q_reg     <= term_next;
            active_cnt_reg <= term_popcount(term_next);
        end
    end

    assign y_q        = y_q_reg;
    assign term_q     = term_q_reg;
    assign active_cnt = active_cnt_reg;

`ifdef AOI5_TOGGLE_CNT_EN
    logic [CNT_W-1:0] toggle_cnt_reg;
    logic [CNT_W-1:0] toggle_cnt_next;

    // Count edges of y_q, holding at all-ones instead of wrapping.
    always_comb begin
        toggle_cnt_next = toggle_cnt_reg;
        if ((Y != y_q_reg) && (toggle_cnt_reg != {CNT_W{1'b1}})) begin
            toggle_cnt_next = toggle_cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            toggle_cnt_reg <= '0;
        end else begin
            toggle_cnt_reg <= toggle_cnt_next;
        end
    end

    assign toggle_cnt = toggle_cnt_reg;
`else
    assign toggle_cnt = '0;
`endif

endmodule

// File: tb/tb_aoi5.sv
// Scoreboard bench for aoi5: driver pushes model expectations, monitor pops
// and compares the registered outputs one cycle later.
module tb_aoi5;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             A = 0, B = 0, C = 0, D = 0, E = 0, F = 0, G = 0, H = 0;
    logic             Y;
    logic             y_q;
    logic [3:0]       term_q;
    logic [2:0]       active_cnt;
    logic [CNT_W-1:0] toggle_cnt;

    aoi5 #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .A          (A),
        .B          (B),
        .C          (C),
        .D          (D),
        .E          (E),
        .F          (F),
        .G          (G),
        .H          (H),
        .Y          (Y),
        .y_q        (y_q),
        .term_q     (term_q),
        .active_cnt (active_cnt),
        .toggle_cnt (toggle_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       y;
        logic [3:0] term;
        logic [2:0] cnt;
        int         tog;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   check_cnt = 0;
    int   pass_cnt  = 0;
    bit   drive_done = 0;

    // Reference model state: previous registered output and toggle tally.
    logic m_y   = 1'b1;
    int   m_tog = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // v bit order: {H,G,F,E,D,C,B,A}
    task automatic drive(input logic r, input logic [7:0] v, input string tag);
        logic [3:0] t;
        logic       yexp;
        exp_t       e;
        @(negedge clk);
        rst = r;
        {H, G, F, E, D, C, B, A} = v;
        for (int i = 0; i < 4; i++) t[i] = v[2*i] & v[2*i+1];
        yexp = (t == 4'b0000);
        #1;
        check({tag, "_Y"}, {31'b0, Y}, {31'b0, yexp});
        if (r) begin
            e.y = 1'b1; e.term = 4'b0000; e.cnt = 3'd0; m_tog = 0;
        end else begin
            e.y = yexp; e.term = t; e.cnt = 3'($countones(t));
`ifdef AOI5_TOGGLE_CNT_EN
            if (yexp != m_y && m_tog < (1 << CNT_W) - 1) m_tog++;
`endif
        end
        m_y   = e.y;
        e.tog = m_tog;
        e.tag = tag;
        sb.push_back(e);
        $display("drive %-8s rst=%0b in=%08b Y=%0b exp_y_q=%0b exp_term=%04b exp_cnt=%0d exp_tog=%0d",
                 tag, r, v, Y, e.y, e.term, e.cnt, e.tog);
    endtask

    // Monitor: one registered transaction per clock once stimulus is queued.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check({e.tag, "_y_q"},        {31'b0, y_q},        {31'b0, e.y});
                check({e.tag, "_term_q"},     {28'b0, term_q},     {28'b0, e.term});
                check({e.tag, "_active_cnt"}, {29'b0, active_cnt}, {29'b0, e.cnt});
                check({e.tag, "_toggle_cnt"}, 32'(toggle_cnt),     32'(e.tog));
            end
        end
    end

    initial begin
        drive(1'b1, 8'h00, "reset");
        drive(1'b1, 8'hFF, "rst_ones");
        drive(1'b0, 8'h00, "zeros");
        drive(1'b0, 8'h55, "aceg");
        drive(1'b0, 8'h03, "ab");
        drive(1'b0, 8'hFF, "ones");
        drive(1'b0, 8'h00, "zeros2");
        // Alternate A&B long enough to drive a 4-bit counter into saturation.
        for (int i = 0; i < (1 << CNT_W) + 5; i++)
            drive(1'b0, (i % 2 == 0) ? 8'h03 : 8'h00, "tog");
        drive(1'b1, 8'h03, "mid_rst");
        drive(1'b0, 8'h30, "post_rst");
        for (int i = 0; i < 200; i++)
            drive(($urandom_range(0, 19) == 0), 8'($urandom), "rand");
        drive_done = 1;
        repeat (3) @(posedge clk);
        #2;
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    // Hard bound on run time.
    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
